// File: rtl/store_buf_pkg.sv
// Shared definitions for the store buffer slice.
// Holds the RV32 width constants and the store-buffer geometry
// (entry count and pointer width) used by store_buf and its
// forwarding search sub-module.
package store_buf_pkg;

  localparam int RV32_ADDR_WIDTH = 32;
  localparam int RV32_DATA_WIDTH = 32;

  // Store-buffer geometry: entry count and log2 of it.
  localparam int STBUF_ENT_NUM = 8;
  localparam int STBUF_ENT_SEL = 3;

endpackage

// File: rtl/store_buf_fwd_search.sv
// stbuf_fwd_search: combinational store-to-load forwarding search.
// Compares the load address against every valid store-buffer entry and
// returns the youngest match, i.e. the one closest to tail-1 in wrap order.
// Ports:
//   valid   - per-entry valid bits
//   addr    - per-entry store addresses
//   tail    - next free slot (entry tail-1 is the youngest)
//   ld_addr - load address being searched
//   hit     - some valid entry matches ld_addr
//   idx     - physical index of the youngest matching entry
module stbuf_fwd_search
  import store_buf_pkg::*;
#(
  parameter int DEPTH = STBUF_ENT_NUM,
  parameter int PTR_W = STBUF_ENT_SEL
) (
  input  logic [DEPTH-1:0]           valid,
  input  logic [RV32_ADDR_WIDTH-1:0] addr [DEPTH],
  input  logic [PTR_W-1:0]           tail,
  input  logic [RV32_ADDR_WIDTH-1:0] ld_addr,
  output logic                       hit,
  output logic [PTR_W-1:0]           idx
);

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] rot_match;
  logic [PTR_W-1:0] rot_idx [DEPTH];

  // Rotate the match vector so that position k holds entry tail-1-k;
  // position 0 is then the youngest entry regardless of wrap.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign match[g]     = valid[g] && (addr[g] == ld_addr);
    assign rot_idx[g]   = tail - PTR_W'(1) - PTR_W'(g);
    assign rot_match[g] = match[rot_idx[g]];
  end

  // Priority encoder: lowest rotated position wins, so iterate from the
  // oldest down and let the last assignment stand.
  always_comb begin
    hit = |rot_match;
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rot_match[k]) begin
        idx = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/store_buf.sv
// store_buf: in-order store buffer between the load/store exec unit,
// the ROB commit path and data memory.
// Stores are allocated at tail when execution finishes, marked committed
// by advancing com, and drained from head to dmem whenever the load path
// leaves the port free. Loads are forwarded the youngest matching entry.
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   i_exfin_st/_addr/_data         - allocate a finished store
//   o_stbuf_full                   - every entry occupied (registered)
//   i_ld_addr, o_stbuf_addr_hit,
//   o_stbuf_rd_data                - forwarding search for loads
//   i_com_st_num                   - stores committed by ROB this cycle (0-2)
//   i_flush                        - discard all uncommitted entries
//   i_dmem_occupy                  - load owns the dmem port this cycle
//   o_dmem_we/_wr_addr/_wr_data    - head entry write to dmem
module store_buf
  import store_buf_pkg::*;
#(
  parameter int DEPTH = STBUF_ENT_NUM,
  parameter int PTR_W = STBUF_ENT_SEL
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_exfin_st,
  input  logic [RV32_ADDR_WIDTH-1:0] i_exfin_st_addr,
  input  logic [RV32_DATA_WIDTH-1:0] i_exfin_st_data,
  output logic                       o_stbuf_full,
  input  logic [RV32_ADDR_WIDTH-1:0] i_ld_addr,
  output logic                       o_stbuf_addr_hit,
  output logic [RV32_DATA_WIDTH-1:0] o_stbuf_rd_data,
  input  logic [1:0]                 i_com_st_num,
  input  logic                       i_flush,
  input  logic                       i_dmem_occupy,
  output logic                       o_dmem_we,
  output logic [RV32_ADDR_WIDTH-1:0] o_dmem_wr_addr,
  output logic [RV32_DATA_WIDTH-1:0] o_dmem_wr_data
);

  logic [PTR_W-1:0]           head, com, tail;
  logic [PTR_W:0]             cnt, ncom;
  logic [DEPTH-1:0]           valid, valid_next;
  logic [RV32_ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [RV32_DATA_WIDTH-1:0] data_q [DEPTH];

  logic                       alloc, drain;
  logic [PTR_W:0]             alloc_ext, drain_ext, com_num_ext;
  logic [PTR_W-1:0]           com_next;
  logic [PTR_W:0]             uncom_left;
  logic [DEPTH-1:0]           flush_kill;
  logic [PTR_W-1:0]           kill_off [DEPTH];

  logic                       fwd_hit;
  logic [PTR_W-1:0]           fwd_idx;

  assign o_stbuf_full = (cnt == (PTR_W+1)'(DEPTH));

  // A store arriving in a flush cycle belongs to the wrong path and is dropped.
  assign alloc = i_exfin_st && !o_stbuf_full && !i_flush;
  assign drain = (ncom != '0) && !i_dmem_occupy;

  assign alloc_ext   = (PTR_W+1)'(alloc);
  assign drain_ext   = (PTR_W+1)'(drain);
  assign com_num_ext = (PTR_W+1)'(i_com_st_num);

  // Same-cycle commits are applied before a flush, so the flush boundary
  // is the post-commit com pointer.
  assign com_next   = com + PTR_W'(i_com_st_num);
  assign uncom_left = cnt - ncom - com_num_ext;

  // An entry is discarded by a flush when its distance from com_next is
  // inside the remaining uncommitted span.
  for (genvar g = 0; g < DEPTH; g++) begin : g_kill
    assign kill_off[g]   = PTR_W'(g) - com_next;
    assign flush_kill[g] = ({1'b0, kill_off[g]} < uncom_left);
  end

  always_comb begin
    valid_next = valid;
    if (i_flush) begin
      valid_next = valid & ~flush_kill;
    end
    if (drain) begin
      valid_next[head] = 1'b0;
    end
    if (alloc) begin
      valid_next[tail] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      com   <= '0;
      tail  <= '0;
      cnt   <= '0;
      ncom  <= '0;
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid <= valid_next;
      com   <= com_next;
      ncom  <= ncom + com_num_ext - drain_ext;
      if (drain) begin
        head <= head + PTR_W'(1);
      end
      // After a flush only committed entries survive, so the occupied
      // count collapses to the new committed count.
      if (i_flush) begin
        tail <= com_next;
        cnt  <= ncom + com_num_ext - drain_ext;
      end else begin
        if (alloc) begin
          tail <= tail + PTR_W'(1);
        end
        cnt <= cnt + alloc_ext - drain_ext;
      end
      if (alloc) begin
        addr_q[tail] <= i_exfin_st_addr;
        data_q[tail] <= i_exfin_st_data;
      end
    end
  end

  stbuf_fwd_search #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd_search (
    .valid   (valid),
    .addr    (addr_q),
    .tail    (tail),
    .ld_addr (i_ld_addr),
    .hit     (fwd_hit),
    .idx     (fwd_idx)
  );

  assign o_stbuf_addr_hit = fwd_hit;
  assign o_stbuf_rd_data  = fwd_hit ? data_q[fwd_idx] : '0;

  assign o_dmem_we      = drain;
  assign o_dmem_wr_addr = addr_q[head];
  assign o_dmem_wr_data = data_q[head];

  a_no_alloc_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(i_exfin_st && o_stbuf_full));

  a_commit_bound : assert property (@(posedge clk) disable iff (!rst_n)
    com_num_ext <= (cnt - ncom));

endmodule

// File: tb/tb_store_buf.sv
// Self-checking bench for store_buf. Directed stimulus drives a small
// reference model of pending/committed stores; committed stores are queued
// as expected dmem writes and a separate monitor pops and compares them
// whenever the DUT asserts o_dmem_we. Forwarding and full flags are checked
// directly against hand-computed values.
module tb_store_buf;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        i_exfin_st;
  logic [31:0] i_exfin_st_addr;
  logic [31:0] i_exfin_st_data;
  logic        o_stbuf_full;
  logic [31:0] i_ld_addr;
  logic        o_stbuf_addr_hit;
  logic [31:0] o_stbuf_rd_data;
  logic [1:0]  i_com_st_num;
  logic        i_flush;
  logic        i_dmem_occupy;
  logic        o_dmem_we;
  logic [31:0] o_dmem_wr_addr;
  logic [31:0] o_dmem_wr_data;

  int   n_checks;
  int   n_fail;
  ent_t pend_q[$];
  ent_t exp_q[$];
  ent_t mon_e;

  store_buf dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_exfin_st       (i_exfin_st),
    .i_exfin_st_addr  (i_exfin_st_addr),
    .i_exfin_st_data  (i_exfin_st_data),
    .o_stbuf_full     (o_stbuf_full),
    .i_ld_addr        (i_ld_addr),
    .o_stbuf_addr_hit (o_stbuf_addr_hit),
    .o_stbuf_rd_data  (o_stbuf_rd_data),
    .i_com_st_num     (i_com_st_num),
    .i_flush          (i_flush),
    .i_dmem_occupy    (i_dmem_occupy),
    .o_dmem_we        (o_dmem_we),
    .o_dmem_wr_addr   (o_dmem_wr_addr),
    .o_dmem_wr_data   (o_dmem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs and advance the reference model.
  // Commits are applied before a flush; a flushed cycle drops its store.
  task automatic applyStimulus(input logic st, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] cn,
                               input logic fl, input logic occ,
                               input logic [31:0] ld);
    i_exfin_st      = st;
    i_exfin_st_addr = a;
    i_exfin_st_data = d;
    i_com_st_num    = cn;
    i_flush         = fl;
    i_dmem_occupy   = occ;
    i_ld_addr       = ld;
    for (int i = 0; i < int'(cn); i++) begin
      if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
    end
    if (fl) pend_q.delete();
    else if (st) pend_q.push_back('{a: a, d: d});
    #1;
  endtask

  task automatic idle(input logic occ, input logic [31:0] ld);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, occ, ld);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every dmem write must match the oldest expected committed store.
  always @(negedge clk) begin
    if (rst_n && o_dmem_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL drain_unexpected: got addr %h data %h expected no write",
                 o_dmem_wr_addr, o_dmem_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_dmem_wr_addr !== mon_e.a || o_dmem_wr_data !== mon_e.d) begin
          n_fail++;
          $display("[TB] FAIL drain_order: got %h/%h expected %h/%h",
                   o_dmem_wr_addr, o_dmem_wr_data, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle(1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_full",    32'(o_stbuf_full), 32'h0);
    checkOutput("rst_hit",     32'(o_stbuf_addr_hit), 32'h0);
    checkOutput("rst_rd_data", o_stbuf_rd_data, 32'h0);
    checkOutput("rst_we",      32'(o_dmem_we), 32'h0);
    checkOutput("rst_wr_addr", o_dmem_wr_addr, 32'h0);
    checkOutput("rst_wr_data", o_dmem_wr_data, 32'h0);
    tick();

    // Single store, commit, drain one cycle after commit.
    $display("[TB] single store drain");
    applyStimulus(1'b1, 32'h100, 32'hAA, 2'd0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 32'h100);
    checkOutput("commit_cycle_we", 32'(o_dmem_we), 32'h0);
    tick();
    idle(1'b0, 32'h100);
    checkOutput("drain_we",      32'(o_dmem_we), 32'h1);
    checkOutput("drain_addr",    o_dmem_wr_addr, 32'h100);
    checkOutput("drain_data",    o_dmem_wr_data, 32'hAA);
    checkOutput("drain_fwd_hit", 32'(o_stbuf_addr_hit), 32'h1);
    checkOutput("drain_fwd_dat", o_stbuf_rd_data, 32'hAA);
    tick();
    idle(1'b0, 32'h100);
    checkOutput("post_drain_we",  32'(o_dmem_we), 32'h0);
    checkOutput("post_drain_hit", 32'(o_stbuf_addr_hit), 32'h0);
    checkOutput("post_drain_full", 32'(o_stbuf_full), 32'h0);
    tick();

    // Youngest-match forwarding; same-cycle allocation is not forwarded.
    $display("[TB] forwarding");
    applyStimulus(1'b1, 32'h40, 32'h1, 2'd0, 1'b0, 1'b0, 32'h40);
    checkOutput("fwd_same_cycle_hit", 32'(o_stbuf_addr_hit), 32'h0);
    tick();
    applyStimulus(1'b1, 32'h40, 32'h2, 2'd0, 1'b0, 1'b0, 32'h40);
    checkOutput("fwd_old_data", o_stbuf_rd_data, 32'h1);
    tick();
    idle(1'b0, 32'h40);
    checkOutput("fwd_hit",   32'(o_stbuf_addr_hit), 32'h1);
    checkOutput("fwd_young", o_stbuf_rd_data, 32'h2);
    idle(1'b0, 32'h44);
    checkOutput("fwd_miss_hit",  32'(o_stbuf_addr_hit), 32'h0);
    checkOutput("fwd_miss_data", o_stbuf_rd_data, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0);
    tick();
    repeat (4) begin idle(1'b0, 32'h0); tick(); end

    // Fill to full; full drops only the cycle after the drain edge.
    $display("[TB] full");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 32'h200 + 32'(4 * k), 32'h10 + 32'(k), 2'd0, 1'b0, 1'b0, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 32'h0);
    checkOutput("full_set", 32'(o_stbuf_full), 32'h1);
    checkOutput("full_commit_we", 32'(o_dmem_we), 32'h0);
    tick();
    idle(1'b0, 32'h0);
    checkOutput("full_drain_we", 32'(o_dmem_we), 32'h1);
    checkOutput("full_during_drain", 32'(o_stbuf_full), 32'h1);
    tick();
    idle(1'b0, 32'h0);
    checkOutput("full_cleared", 32'(o_stbuf_full), 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 32'h0);
    tick();
    repeat (10) begin idle(1'b0, 32'h0); tick(); end

    // Flush with same-cycle commit and a dropped store.
    $display("[TB] flush");
    applyStimulus(1'b1, 32'h300, 32'h31, 2'd0, 1'b0, 1'b1, 32'h0); tick();
    applyStimulus(1'b1, 32'h304, 32'h32, 2'd0, 1'b0, 1'b1, 32'h0); tick();
    applyStimulus(1'b1, 32'h308, 32'h33, 2'd0, 1'b0, 1'b1, 32'h0); tick();
    applyStimulus(1'b0, 32'h0,   32'h0,  2'd1, 1'b0, 1'b1, 32'h0); tick();
    applyStimulus(1'b1, 32'h30C, 32'h34, 2'd1, 1'b1, 1'b1, 32'h0); tick();
    idle(1'b1, 32'h308);
    checkOutput("flush_killed_hit", 32'(o_stbuf_addr_hit), 32'h0);
    idle(1'b1, 32'h30C);
    checkOutput("flush_dropped_hit", 32'(o_stbuf_addr_hit), 32'h0);
    idle(1'b1, 32'h304);
    checkOutput("flush_kept_data", o_stbuf_rd_data, 32'h32);
    tick();
    idle(1'b0, 32'h0);
    checkOutput("flush_drain0_addr", o_dmem_wr_addr, 32'h300);
    tick();
    idle(1'b0, 32'h0);
    checkOutput("flush_drain1_addr", o_dmem_wr_addr, 32'h304);
    tick();
    idle(1'b0, 32'h0);
    checkOutput("flush_empty_we", 32'(o_dmem_we), 32'h0);
    tick();

    // Port held by loads: no writes until released, then back-to-back.
    $display("[TB] dmem occupy");
    applyStimulus(1'b1, 32'h400, 32'h41, 2'd0, 1'b0, 1'b1, 32'h0); tick();
    applyStimulus(1'b1, 32'h404, 32'h42, 2'd0, 1'b0, 1'b1, 32'h0); tick();
    applyStimulus(1'b0, 32'h0,   32'h0,  2'd2, 1'b0, 1'b1, 32'h0); tick();
    for (int k = 0; k < 5; k++) begin
      idle(1'b1, 32'h0);
      checkOutput($sformatf("occupy_we_%0d", k), 32'(o_dmem_we), 32'h0);
      tick();
    end
    idle(1'b0, 32'h0);
    checkOutput("release_we0", 32'(o_dmem_we), 32'h1);
    checkOutput("release_addr0", o_dmem_wr_addr, 32'h400);
    tick();
    idle(1'b0, 32'h0);
    checkOutput("release_we1", 32'(o_dmem_we), 32'h1);
    checkOutput("release_addr1", o_dmem_wr_addr, 32'h404);
    tick();
    idle(1'b0, 32'h0);
    checkOutput("release_done_we", 32'(o_dmem_we), 32'h0);
    tick();

    // Pointer wrap: 20 single-store rounds, then a full ring across the wrap.
    $display("[TB] wrap");
    for (int r = 1; r <= 20; r++) begin
      applyStimulus(1'b1, 32'h0, 32'h600 + 32'(r), 2'd0, 1'b0, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("wrap_round_%0d", r), o_stbuf_rd_data, 32'h600 + 32'(r));
      tick();
      idle(1'b0, 32'h0);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, (k == 0 || k == 3 || k == 7) ? 32'h0 : 32'h8 + 32'(4 * k),
                    32'h500 + 32'(k), 2'd0, 1'b0, 1'b0, 32'h0);
      if (k == 7) checkOutput("wrap_prev_young", o_stbuf_rd_data, 32'h503);
      tick();
    end
    idle(1'b0, 32'h0);
    checkOutput("wrap_full", 32'(o_stbuf_full), 32'h1);
    checkOutput("wrap_hit", 32'(o_stbuf_addr_hit), 32'h1);
    checkOutput("wrap_young", o_stbuf_rd_data, 32'h507);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0);
      tick();
    end
    repeat (12) begin idle(1'b0, 32'h0); tick(); end
    checkOutput("end_exp_empty", 32'(exp_q.size()), 32'h0);
    checkOutput("end_full", 32'(o_stbuf_full), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buf.md
# store_buf

In-order store buffer that receives execute-finished stores from the load/store execution unit and holds them until the reorder buffer commits them. It drains committed stores to data memory whenever the load path is not using the port, and forwards buffered store data to loads on an address match. It is the receiving end of the exec unit's `exfin_st` / `stbuf_full` / `stbuf_addr_hit` handshake.

## Interface
Parameters:
- `DEPTH`, default 8: number of entries; must be a power of two, ≥ 2.
- `PTR_W`, default 3: log2(`DEPTH`).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `i_exfin_st` in 1: store finished execution; allocate the tail entry this cycle.
- `i_exfin_st_addr` in `RV32_ADDR_WIDTH`: store word address.
- `i_exfin_st_data` in `RV32_DATA_WIDTH`: store data.
- `o_stbuf_full` out 1: all `DEPTH` entries occupied.
- `i_ld_addr` in `RV32_ADDR_WIDTH`: load address to search.
- `o_stbuf_addr_hit` out 1: a buffered entry matches `i_ld_addr`.
- `o_stbuf_rd_data` out `RV32_DATA_WIDTH`: data of the youngest matching entry; 0 when there is no hit.
- `i_com_st_num` in 2: number of stores committed by the ROB this cycle, 0–2.
- `i_flush` in 1: misprediction; discard all uncommitted entries.
- `i_dmem_occupy` in 1: load owns the dmem port this cycle.
- `o_dmem_we` out 1: write the head entry to dmem this cycle.
- `o_dmem_wr_addr` out `RV32_ADDR_WIDTH`: head entry address.
- `o_dmem_wr_data` out `RV32_DATA_WIDTH`: head entry data.

## Operation
- Circular FIFO with three pointers:
  - `head`: oldest entry, next to drain.
  - `com`: first uncommitted entry.
  - `tail`: next free entry.
- Two counters, each `PTR_W+1` bits: `cnt` (occupied entries) and `ncom` (committed, not yet drained).
- Invariant: `head` ≤ `com` ≤ `tail` in FIFO order. Pointers wrap modulo `DEPTH`.
- Allocate: when `i_exfin_st` is high, write addr/data at `tail`, set its valid bit, and advance `tail`.
  - Asserting `i_exfin_st` while `o_stbuf_full` is high is a protocol violation; the bench asserts on it and the write is ignored.
- Commit: advance `com` by `i_com_st_num` and increase `ncom` by the same amount.
  - `i_com_st_num` greater than the uncommitted count is a violation (assertion).
- Drain: `o_dmem_we = (ncom != 0) && !i_dmem_occupy`.
  - When set: clear the valid bit at `head`, advance `head`, decrement `cnt` and `ncom`.
- Forward: compare `i_ld_addr` against all valid entries, both committed and uncommitted.
  - Priority goes to the youngest entry, i.e. the one nearest `tail - 1` in wrap order.
  - The search is purely combinational.
- Flush: clear valid bits from (`com` + `i_com_st_num`) up to `tail`, and set `tail` to `com + i_com_st_num`.
  - Same-cycle commits take effect first.
  - A same-cycle `i_exfin_st` is dropped.
  - A same-cycle drain proceeds normally.
- Simultaneous allocate, commit and drain all update their counters in the same cycle. Net `cnt` = `cnt + alloc − drain`.

## Timing
- Reset: all pointers, counters and valid bits go to 0. Outputs after reset: `o_stbuf_full`=0, `o_stbuf_addr_hit`=0, `o_stbuf_rd_data`=0, `o_dmem_we`=0, `o_dmem_wr_addr`=0, `o_dmem_wr_data`=0.
- Reset mid-operation discards every entry, including committed ones.
- `o_stbuf_full` is derived from registered `cnt == DEPTH`.
  - It is not relieved combinationally by a same-cycle drain; the freed slot is visible the next cycle.
- An entry allocated at edge N is:
  - searchable for forwarding from cycle N+1;
  - not forwarded to a load presented in cycle N.
- Commit at edge N makes the entry drainable from cycle N+1. Earliest dmem write is therefore one cycle after commit.
- Drain latency: `o_dmem_we` is combinational; the dmem write and the head advance happen at the same edge.
  - The draining entry still forwards during that cycle.
- Throughput: one drain per cycle, one allocation per cycle.

## Structure
- Width macros `RV32_ADDR_WIDTH` and `RV32_DATA_WIDTH` come from `constants.vh`.
- Add `STBUF_ENT_NUM` and `STBUF_ENT_SEL` there, mapping to `DEPTH` and `PTR_W`.
- One sub-module, `stbuf_fwd_search`:
  - inputs: the valid vector, the address array, `tail`, and the load address;
  - outputs: hit and selected index;
  - implementation: rotate by `tail`, then a priority encoder.
- Everything else (pointers, counters, entry arrays) lives in `store_buf`.

## Test plan
- Store 0x100←0xAA, commit 1, `i_dmem_occupy`=0 → `o_dmem_we`=1 with addr 0x100, data 0xAA one cycle after commit; `cnt` returns to 0.
- Stores 0x40←1 then 0x40←2, load 0x40 → hit=1, data=2. Load 0x44 → hit=0, data=0.
- Fill 8 stores → `o_stbuf_full`=1. Commit 1 and drain → full=0 on the cycle after the drain edge.
- 3 stores, commit 1, and `i_flush` with `i_com_st_num`=1 in the same cycle → 2 entries remain committed; `tail` equals `com`; both entries drain in order.
- Hold `i_dmem_occupy`=1 for 5 cycles with 2 committed entries → no write. Release → writes on 2 consecutive cycles.
- Run 20 store/commit/drain rounds wrapping pointers twice; search 0x0 for an entry spanning the wrap → correct youngest data.
